// File: rtl/rs_sched_pkg.sv
// rs_sched_pkg: sizing helpers and output FIFO entry layout shared by the frame scheduler.
// Entry layout is {tlast, tkeep, tdata} with tdata at the LSBs.
package rs_sched_pkg;

  function automatic int clog2(input int value);
    int bits;
    bits = 32'sd0;
    while ((32'sd1 << bits) < value) bits = bits + 32'sd1;
    return bits;
  endfunction

  // A one-entry index still needs one bit so the pointer registers stay legal.
  function automatic int lane_idx_w(input int num);
    return (num <= 32'sd1) ? 32'sd1 : clog2(num);
  endfunction

  function automatic int keep_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic int last_bit(input int out_w, input int in_w);
    return out_w + out_w / in_w;
  endfunction

  function automatic int entry_w(input int out_w, input int in_w);
    return last_bit(out_w, in_w) + 32'sd1;
  endfunction

endpackage

// File: rtl/rs_sched_fifo.sv
// rs_sched_fifo: single-clock FIFO with registered write and combinational read from storage.
// o_data reads as zero while empty so the scheduler's output bus is clean out of reset.
module rs_sched_fifo
  import rs_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic               core_clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == {(AW+1){1'b0}});
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1'b1);
        2'b01:   r_count <= r_count - (AW+1)'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge core_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rs_frame_scheduler.sv
// rs_frame_scheduler: round-robin frame dispatch to NUM_LANES RS decoders, in-order merge, packing to OUT_W.
// Optional statistics ports are enabled with the RS_SCHED_STATS_EN macro.
module rs_frame_scheduler
  import rs_sched_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                      core_clk,
  input  logic                      rst,
  input  logic [IN_W-1:0]           s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [NUM_LANES*IN_W-1:0] lane_s_tdata,
  output logic [NUM_LANES-1:0]      lane_s_tvalid,
  output logic [NUM_LANES-1:0]      lane_s_tlast,
  input  logic [NUM_LANES-1:0]      lane_s_tready,
  input  logic [NUM_LANES*IN_W-1:0] lane_m_tdata,
  input  logic [NUM_LANES-1:0]      lane_m_tvalid,
  input  logic [NUM_LANES-1:0]      lane_m_tlast,
  output logic [NUM_LANES-1:0]      lane_m_tready,
  output logic [OUT_W-1:0]          m_tdata,
  output logic [OUT_W/IN_W-1:0]     m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
`ifdef RS_SCHED_STATS_EN
  output logic [15:0]               stat_frames_in,
  output logic [15:0]               stat_frames_out,
  output logic [15:0]               stat_stall_cycles,
`endif
  input  logic                      m_tready
);

  localparam int R        = OUT_W / IN_W;
  localparam int LW       = lane_idx_w(NUM_LANES);
  localparam int CW       = lane_idx_w(R);
  localparam int FAW      = clog2(FIFO_DEPTH);
  localparam int KEEP_LSB = keep_lsb(OUT_W);
  localparam int LAST_BIT = last_bit(OUT_W, IN_W);
  localparam int EW       = entry_w(OUT_W, IN_W);

  logic [LW-1:0]    r_wr_lane;
  logic [LW-1:0]    r_rd_lane;
  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_word;

  logic [IN_W-1:0]  w_beat_data;
  logic             w_beat_valid;
  logic             w_beat_last;
  logic             w_accept;
  logic             w_push;
  logic [OUT_W-1:0] w_word;
  logic [R-1:0]     w_keep;
  logic [EW-1:0]    w_entry_in;
  logic [EW-1:0]    w_entry_out;
  logic             w_full;
  logic             w_empty;
  logic [FAW:0]     w_count;
  logic             w_s_hs;

  // Dispatch: only the lane under wr_lane sees the input stream; the rest are held idle.
  always_comb begin
    lane_s_tdata  = {(NUM_LANES*IN_W){1'b0}};
    lane_s_tvalid = {NUM_LANES{1'b0}};
    lane_s_tlast  = {NUM_LANES{1'b0}};
    s_tready      = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_s_tdata[k*IN_W +: IN_W] = (r_wr_lane == LW'(k)) ? s_tdata : {IN_W{1'b0}};
      lane_s_tvalid[k] = (r_wr_lane == LW'(k)) && s_tvalid;
      lane_s_tlast[k]  = (r_wr_lane == LW'(k)) && s_tlast;
      s_tready = s_tready | ((r_wr_lane == LW'(k)) && lane_s_tready[k]);
    end
  end

  // Merge: a lane that finishes early waits until rd_lane reaches it, keeping frame order.
  always_comb begin
    w_beat_data   = {IN_W{1'b0}};
    w_beat_valid  = 1'b0;
    w_beat_last   = 1'b0;
    lane_m_tready = {NUM_LANES{1'b0}};
    for (int k = 0; k < NUM_LANES; k++) begin
      w_beat_data  = w_beat_data | ((r_rd_lane == LW'(k)) ? lane_m_tdata[k*IN_W +: IN_W] : {IN_W{1'b0}});
      w_beat_valid = w_beat_valid | ((r_rd_lane == LW'(k)) && lane_m_tvalid[k]);
      w_beat_last  = w_beat_last | ((r_rd_lane == LW'(k)) && lane_m_tlast[k]);
      lane_m_tready[k] = (r_rd_lane == LW'(k)) && !w_full;
    end
  end

  // Packer: place the accepted symbol at index cnt; symbols past cnt are still zero in r_word.
  always_comb begin
    w_word = r_word;
    w_keep = {R{1'b0}};
    for (int i = 0; i < R; i++) begin
      w_keep[i] = (CW'(i) <= r_cnt);
      w_word[i*IN_W +: IN_W] = (CW'(i) == r_cnt) ? w_beat_data : r_word[i*IN_W +: IN_W];
    end
  end

  assign w_s_hs     = s_tvalid && s_tready;
  assign w_accept   = w_beat_valid && !w_full;
  assign w_push     = w_accept && ((r_cnt == CW'(R-1)) || w_beat_last);
  assign w_entry_in = {w_beat_last, w_keep, w_word};

  // Lane pointers advance on frame boundaries of their own stream, independently of each other.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_wr_lane <= {LW{1'b0}};
      r_rd_lane <= {LW{1'b0}};
    end else begin
      if (w_s_hs && s_tlast)
        r_wr_lane <= (r_wr_lane == LW'(NUM_LANES-1)) ? {LW{1'b0}} : r_wr_lane + LW'(1'b1);
      if (w_accept && w_beat_last)
        r_rd_lane <= (r_rd_lane == LW'(NUM_LANES-1)) ? {LW{1'b0}} : r_rd_lane + LW'(1'b1);
    end
  end

  // Partial word accumulator; cleared whenever a word is handed to the FIFO.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= {CW{1'b0}};
      r_word <= {OUT_W{1'b0}};
    end else if (w_accept) begin
      if (w_push) begin
        r_cnt  <= {CW{1'b0}};
        r_word <= {OUT_W{1'b0}};
      end else begin
        r_cnt  <= r_cnt + CW'(1'b1);
        r_word <= w_word;
      end
    end
  end

  rs_sched_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk (core_clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   (w_entry_in),
    .i_pop    (m_tready && !w_empty),
    .o_data   (w_entry_out),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign m_tvalid = (w_count != {(FAW+1){1'b0}});
  assign m_tdata  = w_entry_out[OUT_W-1:0];
  assign m_tkeep  = w_entry_out[KEEP_LSB +: R];
  assign m_tlast  = w_entry_out[LAST_BIT];

`ifdef RS_SCHED_STATS_EN
  logic [15:0] r_frames_in;
  logic [15:0] r_frames_out;
  logic [15:0] r_stall_cycles;

  // Saturating frame and stall counters.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_frames_in    <= 16'd0;
      r_frames_out   <= 16'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      if (w_s_hs && s_tlast && (r_frames_in != 16'hFFFF))
        r_frames_in <= r_frames_in + 16'd1;
      if (m_tvalid && m_tready && m_tlast && (r_frames_out != 16'hFFFF))
        r_frames_out <= r_frames_out + 16'd1;
      if (w_beat_valid && w_full && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stat_frames_in    = r_frames_in;
  assign stat_frames_out   = r_frames_out;
  assign stat_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_rs_frame_scheduler.sv
// tb_rs_frame_scheduler: random frames through modelled decoder lanes, scoreboard on the packed output.
// Expected words are derived from each frame's byte list when the frame is issued.
`timescale 1ns/1ps
module tb_rs_frame_scheduler;

  localparam int NL    = 3;
  localparam int IN_W  = 8;
  localparam int OUT_W = 32;
  localparam int FD    = 64;
  localparam int R     = OUT_W / IN_W;
  localparam int LMEM  = 512;

  logic                core_clk = 1'b0;
  logic                rst = 1'b0;
  logic [IN_W-1:0]     s_tdata = '0;
  logic                s_tvalid = 1'b0;
  logic                s_tlast = 1'b0;
  logic                s_tready;
  logic [NL*IN_W-1:0]  lane_s_tdata;
  logic [NL-1:0]       lane_s_tvalid;
  logic [NL-1:0]       lane_s_tlast;
  logic [NL-1:0]       lane_s_tready = '0;
  logic [NL*IN_W-1:0]  lane_m_tdata = '0;
  logic [NL-1:0]       lane_m_tvalid = '0;
  logic [NL-1:0]       lane_m_tlast = '0;
  logic [NL-1:0]       lane_m_tready;
  logic [OUT_W-1:0]    m_tdata;
  logic [R-1:0]        m_tkeep;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready = 1'b0;
`ifdef RS_SCHED_STATS_EN
  logic [15:0]         stat_frames_in;
  logic [15:0]         stat_frames_out;
  logic [15:0]         stat_stall_cycles;
`endif

  rs_frame_scheduler #(
    .NUM_LANES(NL), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FD)
  ) dut (
    .core_clk(core_clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .lane_s_tdata(lane_s_tdata), .lane_s_tvalid(lane_s_tvalid),
    .lane_s_tlast(lane_s_tlast), .lane_s_tready(lane_s_tready),
    .lane_m_tdata(lane_m_tdata), .lane_m_tvalid(lane_m_tvalid),
    .lane_m_tlast(lane_m_tlast), .lane_m_tready(lane_m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid),
`ifdef RS_SCHED_STATS_EN
    .stat_frames_in(stat_frames_in), .stat_frames_out(stat_frames_out),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .m_tready(m_tready)
  );

  always #5 core_clk = ~core_clk;

  typedef struct packed {
    logic             last;
    logic [R-1:0]     keep;
    logic [OUT_W-1:0] data;
  } word_t;

  word_t           exp_q[$];
  logic [IN_W:0]   send_q[$];
  logic [IN_W:0]   lane_mem [NL][LMEM];
  int              lane_wr [NL];
  int              lane_rd [NL];
  int              n_tests = 0;
  int              n_fail = 0;
  int              exp_wr = 0;
  int              exp_rd = 0;
  int              s_prob = 100;
  int              ls_prob = 100;
  int              lo_prob = 100;
  int              m_prob = 100;
  logic [NL-1:0]   lane_out_en = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue a frame for sending and record the words it must produce, R symbols per word.
  task automatic push_frame(input int len, input int first, input bit rnd);
    logic [IN_W-1:0] b[$];
    word_t wd;
    int nw;
    for (int i = 0; i < len; i++) begin
      b.push_back(rnd ? IN_W'($urandom) : IN_W'(first + i));
      send_q.push_back({(i == len - 1), b[i]});
    end
    nw = (len + R - 1) / R;
    for (int w = 0; w < nw; w++) begin
      wd = '0;
      for (int j = 0; j < R; j++) begin
        if (w * R + j < len) begin
          wd.data[j*IN_W +: IN_W] = b[w * R + j];
          wd.keep[j] = 1'b1;
        end
      end
      wd.last = (w == nw - 1);
      exp_q.push_back(wd);
    end
  endtask

  // One cycle: drive after the edge, then check routing and record handshakes on the falling edge.
  task automatic step();
    logic [NL-1:0] wr_sel;
    logic [NL-1:0] rd_sel;
    @(posedge core_clk);
    #1;
    s_tvalid = (send_q.size() > 0) && ($urandom_range(99) < s_prob);
    {s_tlast, s_tdata} = (send_q.size() > 0) ? send_q[0] : '0;
    for (int k = 0; k < NL; k++) begin
      lane_s_tready[k] = ($urandom_range(99) < ls_prob);
      lane_m_tvalid[k] = lane_out_en[k] && (lane_wr[k] != lane_rd[k]) && ($urandom_range(99) < lo_prob);
      {lane_m_tlast[k], lane_m_tdata[k*IN_W +: IN_W]} = lane_mem[k][lane_rd[k] % LMEM];
    end
    m_tready = ($urandom_range(99) < m_prob);
    @(negedge core_clk);
    wr_sel = '0;
    wr_sel[exp_wr] = 1'b1;
    rd_sel = '0;
    rd_sel[exp_rd] = 1'b1;
    check("dispatch_valid", lane_s_tvalid, s_tvalid ? wr_sel : '0);
    check("s_tready_route", s_tready, lane_s_tready[exp_wr]);
    check("merge_ready_other_lanes", lane_m_tready & ~rd_sel, '0);
    if (s_tvalid)
      check("dispatch_data", {lane_s_tlast[exp_wr], lane_s_tdata[exp_wr*IN_W +: IN_W]}, {s_tlast, s_tdata});
    if (s_tvalid && s_tready) begin
      void'(send_q.pop_front());
      if (s_tlast) exp_wr = (exp_wr + 1) % NL;
    end
    for (int k = 0; k < NL; k++) begin
      if (lane_s_tvalid[k] && lane_s_tready[k]) begin
        lane_mem[k][lane_wr[k] % LMEM] = {lane_s_tlast[k], lane_s_tdata[k*IN_W +: IN_W]};
        lane_wr[k]++;
      end
      if (lane_m_tvalid[k] && lane_m_tready[k]) begin
        lane_rd[k]++;
        if (lane_m_tlast[k] && k == exp_rd) exp_rd = (exp_rd + 1) % NL;
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    check(name, 64'(send_q.size() + exp_q.size()), 64'd0);
  endtask

  // Output monitor: every accepted output word must match the head of the scoreboard.
  initial begin
    word_t e;
    forever begin
      @(negedge core_clk);
      if (!rst && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got word %0h expected none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_keep", m_tkeep, e.keep);
          check("out_last", m_tlast, e.last);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NL; k++) begin
      lane_wr[k] = 0;
      lane_rd[k] = 0;
    end
    #2 rst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 8'h5A;
    lane_s_tready = 3'b001;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_lane_m_tready", lane_m_tready, 3'b001);
    check("rst_lane_s_tvalid", lane_s_tvalid, 3'b001);
    check("rst_lane_s_tdata", lane_s_tdata, 24'h00005A);
    check("rst_s_tready", s_tready, 1'b1);
    @(posedge core_clk);
    #1;
    s_tvalid = 1'b0;
    rst = 1'b0;

    // Lane 1 finishes first but must wait for lane 0.
    lane_out_en = 3'b010;
    push_frame(4, 'h01, 1'b0);
    push_frame(4, 'h05, 1'b0);
    repeat (40) step();
    check("held_while_lane0_blocked", m_tvalid, 0);
    lane_out_en = '1;
    drain("drain_ordered", 200);

    push_frame(6, 'h11, 1'b0);
    drain("drain_six", 200);
    push_frame(1, 'h77, 1'b0);
    drain("drain_single", 200);

    s_prob = 70; ls_prob = 75; lo_prob = 65; m_prob = 70;
    for (int f = 0; f < 60; f++) push_frame($urandom_range(1, 9), 0, 1'b1);
    drain("drain_random", 6000);

    // Back-pressure: hold the output until the FIFO fills.
    s_prob = 100; ls_prob = 100; lo_prob = 100; m_prob = 0;
    for (int f = 0; f < 70; f++) push_frame(4, 0, 1'b1);
    repeat (400) step();
    check("full_lane_m_tready", lane_m_tready, 3'b000);
    check("full_m_tvalid", m_tvalid, 1'b1);
    m_prob = 100;
    drain("drain_full", 1500);

    // Leave two words queued and a partial word in the packer, then reset.
    m_prob = 0;
    push_frame(4, 'hB0, 1'b0);
    push_frame(4, 'hB4, 1'b0);
    send_q.push_back({1'b0, 8'hC1});
    send_q.push_back({1'b0, 8'hC2});
    repeat (20) step();
    check("pre_rst_m_tvalid", m_tvalid, 1'b1);
    #2;
    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 8'h3C;
    s_tlast = 1'b0;
    lane_s_tready = '1;
    lane_m_tvalid = '0;
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_rd_lane", lane_m_tready, 3'b001);
    check("midrst_wr_lane", lane_s_tvalid, 3'b001);
    check("midrst_wr_data", lane_s_tdata, 24'h00003C);
    send_q.delete();
    exp_q.delete();
    for (int k = 0; k < NL; k++) lane_rd[k] = lane_wr[k];
    exp_wr = 0;
    exp_rd = 0;
    @(posedge core_clk);
    #1;
    s_tvalid = 1'b0;
    rst = 1'b0;
    m_prob = 100;
    push_frame(3, 'hA1, 1'b0);
    push_frame(5, 0, 1'b1);
    push_frame(2, 0, 1'b1);
    drain("drain_after_rst", 300);
`ifdef RS_SCHED_STATS_EN
    check("stat_frames_in", stat_frames_in, 16'd3);
    check("stat_frames_out", stat_frames_out, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
